program_loader: RTL and testbench
=================================

PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 The block SHALL have parameter MEMORY_DEPTH, default 64, meaning the number of program-memory words (power of two, 2..256).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning the instruction word width in bits (fixed multiple of 8).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port Start_i, input, 1 bit: a one-cycle request to begin a load.
REQ-006 The block SHALL have port Byte_i, input, 8 bits: the incoming stream byte.
REQ-007 The block SHALL have port Byte_Valid_i, input, 1 bit: Byte_i is valid.
REQ-008 The block SHALL have port Byte_Ready_o, output, 1 bit: the loader accepts a byte this cycle.
REQ-009 The block SHALL have port Mem_Write_o, output, 1 bit: the program-memory write strobe.
REQ-010 The block SHALL have port Mem_Address_o, output, $clog2(MEMORY_DEPTH) bits: the word address for the write.
REQ-011 The block SHALL have port Mem_Data_o, output, DATA_WIDTH bits: the instruction word to write.
REQ-012 The block SHALL have port Busy_o, output, 1 bit: a load is in progress, and the core SHALL be held in reset.
REQ-013 The block SHALL have port Done_o, output, 1 bit: a one-cycle pulse marking load completion.
REQ-014 The block SHALL have port Error_o, output, 1 bit: the length header was illegal; this output is sticky.
REQ-015 The block SHALL have port Words_Loaded_o, output, 9 bits: the count of words written in the current or last load.

Function
REQ-016 The FSM SHALL have states IDLE, LEN, DATA, WRITE, DONE and ERR.
REQ-017 A byte SHALL be accepted only on a rising edge where Byte_Valid_i=1 and Byte_Ready_o=1; Byte_Ready_o SHALL be 1 only in LEN and DATA.
REQ-018 In IDLE or ERR, Start_i=1 SHALL move to LEN and clear Error_o, Words_Loaded_o and the address to 0; Start_i in any other state SHALL be ignored.
REQ-019 In LEN, the accepted byte SHALL be latched as N: if 1<=N<=MEMORY_DEPTH the FSM SHALL go to DATA, else to ERR with Error_o=1.
REQ-020 In DATA, accepted bytes SHALL be packed little-endian: the first byte goes to bits [7:0], and the (DATA_WIDTH/8)th byte SHALL complete the word and move the FSM to WRITE.
REQ-021 WRITE SHALL last exactly one cycle, with Mem_Write_o=1 and Mem_Address_o/Mem_Data_o registered and stable; on exit the address and Words_Loaded_o SHALL increment by 1.
REQ-022 After WRITE, if Words_Loaded_o (post-increment) equals N the FSM SHALL go to DONE, else back to DATA with the byte-lane counter reset to 0.
REQ-023 DONE SHALL last one cycle with Done_o=1, then the FSM SHALL go to IDLE.
REQ-024 Mem_Write_o SHALL be 0 in every state other than WRITE; addresses SHALL never exceed MEMORY_DEPTH-1, and no wrap-around SHALL occur.
REQ-025 Busy_o SHALL be 1 in LEN, DATA, WRITE and DONE, and 0 in IDLE and ERR.
REQ-026 Byte_Valid_i gaps of any length SHALL stall the assembly with no timeout and no data loss.
REQ-027 Words_Loaded_o, Mem_Address_o and Mem_Data_o SHALL hold their last values in IDLE and ERR.

Reset
REQ-028 Asserting reset SHALL immediately force IDLE, with all outputs 0 and the internal counters and N cleared.
REQ-029 Reset asserted mid-load SHALL abort the load with no further write strobes; a partially assembled word SHALL be discarded.
REQ-030 After reset deassertion, the block SHALL wait for Start_i; stream bytes arriving in IDLE SHALL not be accepted.

Verification
REQ-031 Start_i, then bytes 02, 13,00,00,00, 93,00,10,00 with continuous valid -> writes 0x00000013@0 and 0x00100093@1; Done_o pulses once; Words_Loaded_o=2; Busy_o falls with the end of DONE.
REQ-032 Start_i, then length byte 00 (and separately 41 with MEMORY_DEPTH=64) -> ERR, Error_o=1, no Mem_Write_o; a later Start_i clears Error_o.
REQ-033 Valid toggled 1/0 every cycle during a 1-word load -> identical word and address as the continuous case; Byte_Ready_o=0 during WRITE.
REQ-034 Reset pulsed after 2 data bytes of a 3-word load -> outputs 0 at once; no write occurs; a following full load starts at address 0.
REQ-035 Start_i pulsed during DATA -> ignored; the load completes normally; Words_Loaded_o=N.
REQ-036 A load with N=64 (MEMORY_DEPTH=64) -> the last write goes to address 63; Done_o pulses; Words_Loaded_o=64.

Source files
------------

// File: rtl/program_loader.sv
// Program loader: receives a byte stream (length header + little-endian
// instruction words) and writes the words into program memory while the
// core is held in reset through Busy_o.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for Start_i; stream bytes are not accepted
// LEN   | waiting for the length header byte N (words to load)
// DATA  | packing stream bytes into the current instruction word
// WRITE | one-cycle program-memory write of the assembled word
// DONE  | one-cycle completion pulse, then back to IDLE
// ERR   | illegal length header seen; Error_o held until next Start_i
module program_loader #(
  parameter int MEMORY_DEPTH = 64,
  parameter int DATA_WIDTH   = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            Start_i,
  input  logic [7:0]                      Byte_i,
  input  logic                            Byte_Valid_i,
  output logic                            Byte_Ready_o,
  output logic                            Mem_Write_o,
  output logic [$clog2(MEMORY_DEPTH)-1:0] Mem_Address_o,
  output logic [DATA_WIDTH-1:0]           Mem_Data_o,
  output logic                            Busy_o,
  output logic                            Done_o,
  output logic                            Error_o,
  output logic [8:0]                      Words_Loaded_o
);

  localparam int ADDR_W = $clog2(MEMORY_DEPTH);
  localparam int LANES  = DATA_WIDTH / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [8:0]        DEPTH_9   = 9'(MEMORY_DEPTH);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN   = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  logic [7:0]              r_n;
  logic [8:0]              r_words;
  logic [ADDR_W-1:0]       r_addr;
  logic [LANE_W-1:0]       r_lane;
  logic [DATA_WIDTH-1:0]   r_word;
  logic [DATA_WIDTH-1:0]   r_mem_data;
  logic                    r_error;

  logic                    w_accept;
  logic                    w_len_ok;
  logic                    w_last_lane;
  logic                    w_load_done;
  logic [8:0]              w_words_inc;
  logic [DATA_WIDTH-1:0]   w_word_next;

  // A byte moves only when the stream offers it and the FSM is listening.
  assign w_accept    = Byte_Valid_i && ((r_state == LEN) || (r_state == DATA));
  assign w_len_ok    = (Byte_i != 8'd0) && ({1'b0, Byte_i} <= DEPTH_9);
  assign w_last_lane = (r_lane == LAST_LANE);
  assign w_words_inc = r_words + 9'd1;
  assign w_load_done = (w_words_inc == {1'b0, r_n});

  // Current word with the incoming byte dropped into its lane (little-endian).
  always_comb begin
    w_word_next = r_word;
    w_word_next[{r_lane, 3'b000} +: 8] = Byte_i;
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and state-derived strobes.
  always_comb begin
    w_next_state = r_state;
    Byte_Ready_o = 1'b0;
    Mem_Write_o  = 1'b0;
    Busy_o       = 1'b0;
    Done_o       = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start_i) w_next_state = LEN;
      end
      LEN: begin
        Byte_Ready_o = 1'b1;
        Busy_o       = 1'b1;
        if (w_accept) w_next_state = w_len_ok ? DATA : ERR;
      end
      DATA: begin
        Byte_Ready_o = 1'b1;
        Busy_o       = 1'b1;
        if (w_accept && w_last_lane) w_next_state = WRITE;
      end
      WRITE: begin
        Mem_Write_o  = 1'b1;
        Busy_o       = 1'b1;
        w_next_state = w_load_done ? DONE : DATA;
      end
      DONE: begin
        Busy_o       = 1'b1;
        Done_o       = 1'b1;
        w_next_state = IDLE;
      end
      ERR: begin
        if (Start_i) w_next_state = LEN;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, address and word counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n        <= '0;
      r_words    <= '0;
      r_addr     <= '0;
      r_lane     <= '0;
      r_word     <= '0;
      r_mem_data <= '0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ERR: begin
          if (Start_i) begin
            r_error <= 1'b0;
            r_words <= '0;
            r_addr  <= '0;
            r_lane  <= '0;
            r_word  <= '0;
          end
        end
        LEN: begin
          if (w_accept) begin
            r_n <= Byte_i;
            if (!w_len_ok) r_error <= 1'b1;
          end
        end
        DATA: begin
          if (w_accept) begin
            r_word <= w_word_next;
            if (w_last_lane) begin
              r_mem_data <= w_word_next;
              r_lane     <= '0;
            end else begin
              r_lane <= r_lane + LANE_W'(1);
            end
          end
        end
        WRITE: begin
          r_words <= w_words_inc;
          // The final write leaves the address on the last word written so a
          // full-depth load never wraps back to 0.
          if (!w_load_done) r_addr <= r_addr + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign Mem_Address_o  = r_addr;
  assign Mem_Data_o     = r_mem_data;
  assign Error_o        = r_error;
  assign Words_Loaded_o = r_words;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader (64 words x 32 bits).
module tb_program_loader;

  localparam int MD = 64;
  localparam int DW = 32;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Start_i = 1'b0;
  logic [7:0]    Byte_i = 8'h00;
  logic          Byte_Valid_i = 1'b0;
  logic          Byte_Ready_o;
  logic          Mem_Write_o;
  logic [AW-1:0] Mem_Address_o;
  logic [DW-1:0] Mem_Data_o;
  logic          Busy_o;
  logic          Done_o;
  logic          Error_o;
  logic [8:0]    Words_Loaded_o;

  program_loader #(.MEMORY_DEPTH(MD), .DATA_WIDTH(DW)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .Start_i       (Start_i),
    .Byte_i        (Byte_i),
    .Byte_Valid_i  (Byte_Valid_i),
    .Byte_Ready_o  (Byte_Ready_o),
    .Mem_Write_o   (Mem_Write_o),
    .Mem_Address_o (Mem_Address_o),
    .Mem_Data_o    (Mem_Data_o),
    .Busy_o        (Busy_o),
    .Done_o        (Done_o),
    .Error_o       (Error_o),
    .Words_Loaded_o(Words_Loaded_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write / done capture, sampled mid-cycle.
  logic [AW-1:0] wr_addr [256];
  logic [DW-1:0] wr_data [256];
  int wr_cnt = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (Mem_Write_o) begin
      if (wr_cnt < 256) begin
        wr_addr[wr_cnt] = Mem_Address_o;
        wr_data[wr_cnt] = Mem_Data_o;
      end
      wr_cnt++;
      chk("ready_in_write", Byte_Ready_o, 0);
    end
    if (Done_o) begin
      done_cnt++;
      chk("busy_in_done", Busy_o, 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    Start_i = 1'b1;
    tick();
    Start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    Byte_i = b;
    Byte_Valid_i = 1'b1;
    while (!Byte_Ready_o && t < 50) begin
      tick();
      t++;
    end
    if (t >= 50) chk("byte_ready_timeout", 0, 1);
    tick();
    Byte_Valid_i = 1'b0;
  endtask

  task automatic load_word(input logic [31:0] w, input bit gap);
    for (int i = 0; i < 4; i++) begin
      send_byte(w[i*8 +: 8]);
      if (gap) tick();
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while (Busy_o && t < 2000) begin
      tick();
      t++;
    end
    if (t >= 2000) chk("idle_timeout", 0, 1);
  endtask

  function automatic logic [31:0] pat(input int k);
    logic [7:0] b;
    b = k[7:0];
    return {b + 8'd3, 8'hA5, ~b, b};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int dbase;

    repeat (3) tick();
    chk("rst_strobes", {Byte_Ready_o, Mem_Write_o, Busy_o, Done_o, Error_o}, 0);
    chk("rst_addr", Mem_Address_o, 0);
    chk("rst_data", Mem_Data_o, 0);
    chk("rst_words", Words_Loaded_o, 0);
    reset = 1'b0;
    tick();

    // Stream bytes offered in IDLE are ignored.
    Byte_i = 8'h02;
    Byte_Valid_i = 1'b1;
    repeat (3) tick();
    chk("idle_ready", Byte_Ready_o, 0);
    chk("idle_busy", Busy_o, 0);
    Byte_Valid_i = 1'b0;
    tick();

    // Two-word load, continuous valid.
    base = wr_cnt;
    dbase = done_cnt;
    pulse_start();
    chk("start_busy", Busy_o, 1);
    send_byte(8'h02);
    load_word(32'h0000_0013, 1'b0);
    load_word(32'h0010_0093, 1'b0);
    chk("t1_write_strobe", Mem_Write_o, 1);
    chk("t1_write_addr", Mem_Address_o, 1);
    chk("t1_write_data", Mem_Data_o, 32'h0010_0093);
    tick();
    chk("t1_done_cycle", {Done_o, Busy_o, Mem_Write_o}, 3'b110);
    tick();
    chk("t1_after_done", {Done_o, Busy_o}, 2'b00);
    chk("t1_wr_count", wr_cnt - base, 2);
    chk("t1_addr0", wr_addr[base], 0);
    chk("t1_data0", wr_data[base], 32'h0000_0013);
    chk("t1_addr1", wr_addr[base+1], 1);
    chk("t1_data1", wr_data[base+1], 32'h0010_0093);
    chk("t1_done_pulses", done_cnt - dbase, 1);
    chk("t1_words", Words_Loaded_o, 2);
    repeat (2) tick();
    chk("t1_hold_data", Mem_Data_o, 32'h0010_0093);
    chk("t1_hold_addr", Mem_Address_o, 1);

    // Illegal headers: 0 and 65.
    base = wr_cnt;
    pulse_start();
    send_byte(8'h00);
    chk("t2_err_zero", Error_o, 1);
    chk("t2_err_busy", {Busy_o, Byte_Ready_o}, 0);
    chk("t2_words_cleared", Words_Loaded_o, 0);
    repeat (3) tick();
    chk("t2_err_sticky", Error_o, 1);
    pulse_start();
    chk("t2_err_cleared", Error_o, 0);
    chk("t2_len_busy", Busy_o, 1);
    send_byte(8'h41);
    chk("t2_err_65", Error_o, 1);
    tick();
    chk("t2_no_writes", wr_cnt - base, 0);

    // One-word load with valid toggling every cycle, started from ERR.
    base = wr_cnt;
    pulse_start();
    chk("t3_err_cleared", Error_o, 0);
    send_byte(8'h01);
    tick();
    load_word(32'h0000_0013, 1'b1);
    wait_idle();
    chk("t3_wr_count", wr_cnt - base, 1);
    chk("t3_addr0", wr_addr[base], 0);
    chk("t3_data0", wr_data[base], 32'h0000_0013);
    chk("t3_words", Words_Loaded_o, 1);

    // Reset in the middle of a three-word load.
    base = wr_cnt;
    pulse_start();
    send_byte(8'h03);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    #1;
    chk("t4_rst_strobes", {Byte_Ready_o, Mem_Write_o, Busy_o, Done_o, Error_o}, 0);
    chk("t4_rst_addr", Mem_Address_o, 0);
    chk("t4_rst_data", Mem_Data_o, 0);
    chk("t4_rst_words", Words_Loaded_o, 0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    chk("t4_no_writes", wr_cnt - base, 0);
    chk("t4_idle", Busy_o, 0);
    pulse_start();
    send_byte(8'h02);
    load_word(32'hDEAD_BEEF, 1'b0);
    load_word(32'h1234_5678, 1'b0);
    wait_idle();
    chk("t4_wr_count", wr_cnt - base, 2);
    chk("t4_addr0", wr_addr[base], 0);
    chk("t4_data0", wr_data[base], 32'hDEAD_BEEF);
    chk("t4_addr1", wr_addr[base+1], 1);
    chk("t4_data1", wr_data[base+1], 32'h1234_5678);
    chk("t4_words", Words_Loaded_o, 2);

    // Start_i pulsed mid-word during DATA is ignored.
    base = wr_cnt;
    dbase = done_cnt;
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_start();
    chk("t5_still_busy", Busy_o, 1);
    chk("t5_words_mid", Words_Loaded_o, 0);
    send_byte(8'h33);
    send_byte(8'h44);
    load_word(32'h8877_6655, 1'b0);
    wait_idle();
    chk("t5_wr_count", wr_cnt - base, 2);
    chk("t5_addr0", wr_addr[base], 0);
    chk("t5_data0", wr_data[base], 32'h4433_2211);
    chk("t5_addr1", wr_addr[base+1], 1);
    chk("t5_data1", wr_data[base+1], 32'h8877_6655);
    chk("t5_words", Words_Loaded_o, 2);
    chk("t5_done_pulses", done_cnt - dbase, 1);

    // Full-depth load, N = 64.
    base = wr_cnt;
    dbase = done_cnt;
    pulse_start();
    send_byte(8'h40);
    chk("t6_no_err", Error_o, 0);
    for (int k = 0; k < MD; k++) load_word(pat(k), 1'b0);
    wait_idle();
    chk("t6_wr_count", wr_cnt - base, 64);
    for (int k = 0; k < MD; k++) begin
      chk($sformatf("t6_addr%0d", k), wr_addr[base+k], k);
      chk($sformatf("t6_data%0d", k), wr_data[base+k], pat(k));
    end
    chk("t6_words", Words_Loaded_o, 64);
    chk("t6_done_pulses", done_cnt - dbase, 1);
    chk("t6_last_addr", Mem_Address_o, 63);
    chk("t6_idle_err", Error_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
